// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for the 16-bit processor datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB/PC_UPD per instruction and drives every
// datapath strobe from registers. Supports free-run, single-step and a sticky HALT.
// The instruction class input is named instr_type because "type" is a
// reserved word in SystemVerilog.
// Optional build macro CTRL_RETIRE_CNT_EN adds the retired_count[15:0] output,
// a wrapping count of completed PC_UPD cycles (cleared by reset, frozen in HALT).
module control_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter int MEM_WAIT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic [1:0]  instr_type,
  input  logic [4:0]  opcode,
  output logic        clk_enable,
  output logic        dm_read_enable,
  output logic        dm_write_enable,
  output logic        reg_write_en,
  output logic        alu_imm,
  output logic        display,
  output logic [1:0]  data_to_reg,
  output logic        pc_butt,
  output logic        halted,
  output logic [2:0]  state
`ifdef CTRL_RETIRE_CNT_EN
  ,
  output logic [15:0] retired_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_PC_UPD = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU_REG,
    CLS_ALU_IMM,
    CLS_DISP,
    CLS_LOAD,
    CLS_STORE,
    CLS_LOADI,
    CLS_MOVACC,
    CLS_JUMP,
    CLS_HALT,
    CLS_NOP
  } cls_t;

  // Counters run down to zero, so they are preloaded with (cycles - 1).
  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);
  localparam logic [3:0] MEM_LOAD  = 4'(MEM_WAIT - 1);

  state_t     cur_state;
  cls_t       cls;
  cls_t       dec_cls;
  logic [3:0] exec_cnt;
  logic [3:0] mem_cnt;

  function automatic cls_t decode_class(input logic [1:0] t, input logic [4:0] op);
    cls_t c;
    c = CLS_NOP;
    case (t)
      2'b00: c = CLS_ALU_REG;
      2'b01: c = CLS_ALU_IMM;
      2'b11: c = CLS_DISP;
      default: begin
        case (op)
          5'b00001: c = CLS_LOAD;
          5'b00010: c = CLS_STORE;
          5'b00011: c = CLS_LOADI;
          5'b00100: c = CLS_MOVACC;
          5'b10100: c = CLS_JUMP;
          5'b11111: c = CLS_HALT;
          default:  c = CLS_NOP;
        endcase
      end
    endcase
    return c;
  endfunction

  assign dec_cls = decode_class(instr_type, opcode);
  assign state   = cur_state;

  // Sequencer: next state and the registered strobes for that next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state       <= S_IDLE;
      cls             <= CLS_NOP;
      exec_cnt        <= 4'd0;
      mem_cnt         <= 4'd0;
      clk_enable      <= 1'b0;
      dm_read_enable  <= 1'b0;
      dm_write_enable <= 1'b0;
      reg_write_en    <= 1'b0;
      alu_imm         <= 1'b0;
      display         <= 1'b0;
      data_to_reg     <= 2'b00;
      pc_butt         <= 1'b0;
      halted          <= 1'b0;
    end else begin
      // Single-cycle strobes drop unless the next state re-asserts them.
      clk_enable      <= 1'b0;
      dm_read_enable  <= 1'b0;
      dm_write_enable <= 1'b0;
      reg_write_en    <= 1'b0;
      pc_butt         <= 1'b0;
      unique case (cur_state)
        S_IDLE: begin
          if (run || step) cur_state <= S_FETCH;
        end
        S_FETCH: begin
          // Instruction memory has settled: classify and set decode strobes.
          cls         <= dec_cls;
          cur_state   <= S_DECODE;
          alu_imm     <= (dec_cls == CLS_ALU_IMM);
          display     <= (dec_cls == CLS_DISP) && (opcode == 5'b10111);
          data_to_reg <= (dec_cls == CLS_LOAD)   ? 2'b01 :
                         (dec_cls == CLS_MOVACC) ? 2'b10 :
                         (dec_cls == CLS_LOADI)  ? 2'b11 : 2'b00;
        end
        S_DECODE: begin
          case (cls)
            CLS_ALU_REG, CLS_ALU_IMM, CLS_DISP: begin
              cur_state  <= S_EXEC;
              exec_cnt   <= EXEC_LOAD;
              clk_enable <= 1'b1;
            end
            CLS_LOAD: begin
              cur_state      <= S_MEM;
              mem_cnt        <= MEM_LOAD;
              dm_read_enable <= 1'b1;
            end
            CLS_STORE: begin
              cur_state       <= S_MEM;
              dm_write_enable <= 1'b1;
              clk_enable      <= 1'b1;
            end
            CLS_LOADI, CLS_MOVACC: begin
              cur_state    <= S_WB;
              reg_write_en <= 1'b1;
              clk_enable   <= 1'b1;
            end
            CLS_HALT: begin
              cur_state <= S_HALT;
              halted    <= 1'b1;
            end
            default: begin
              cur_state <= S_PC_UPD;
              pc_butt   <= 1'b1;
            end
          endcase
        end
        S_EXEC: begin
          if (exec_cnt == 4'd0) begin
            cur_state <= S_PC_UPD;
            pc_butt   <= 1'b1;
          end else begin
            exec_cnt   <= exec_cnt - 4'd1;
            clk_enable <= 1'b1;
          end
        end
        S_MEM: begin
          if (cls == CLS_LOAD) begin
            dm_read_enable <= 1'b1;
            if (mem_cnt == 4'd0) begin
              cur_state    <= S_WB;
              reg_write_en <= 1'b1;
              clk_enable   <= 1'b1;
            end else begin
              mem_cnt <= mem_cnt - 4'd1;
            end
          end else begin
            cur_state <= S_PC_UPD;
            pc_butt   <= 1'b1;
          end
        end
        S_WB: begin
          cur_state <= S_PC_UPD;
          pc_butt   <= 1'b1;
        end
        S_PC_UPD: begin
          cur_state   <= run ? S_FETCH : S_IDLE;
          alu_imm     <= 1'b0;
          display     <= 1'b0;
          data_to_reg <= 2'b00;
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: cur_state <= S_IDLE;
      endcase
    end
  end

`ifdef CTRL_RETIRE_CNT_EN
  // Retired-instruction counter: one count per PC_UPD cycle, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_count <= 16'd0;
    end else if (cur_state == S_PC_UPD) begin
      retired_count <= retired_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (default and EXEC_CYCLES=3/MEM_WAIT=3)
// checked every cycle against a trace-building reference model.
module tb_control_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, run, step;
  logic [1:0] instr_type;
  logic [4:0] opcode;

  logic a_ce, a_rd, a_wr, a_we, a_ai, a_dp, a_pc, a_h;
  logic b_ce, b_rd, b_wr, b_we, b_ai, b_dp, b_pc, b_h;
  logic [1:0] a_dtr, b_dtr;
  logic [2:0] a_st, b_st;
`ifdef CTRL_RETIRE_CNT_EN
  logic [15:0] a_rc, b_rc;
`endif

  control_sequencer dut_a (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .instr_type(instr_type), .opcode(opcode),
    .clk_enable(a_ce), .dm_read_enable(a_rd), .dm_write_enable(a_wr),
    .reg_write_en(a_we), .alu_imm(a_ai), .display(a_dp), .data_to_reg(a_dtr),
    .pc_butt(a_pc), .halted(a_h), .state(a_st)
`ifdef CTRL_RETIRE_CNT_EN
    , .retired_count(a_rc)
`endif
  );

  control_sequencer #(.EXEC_CYCLES(3), .MEM_WAIT(3)) dut_b (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .instr_type(instr_type), .opcode(opcode),
    .clk_enable(b_ce), .dm_read_enable(b_rd), .dm_write_enable(b_wr),
    .reg_write_en(b_we), .alu_imm(b_ai), .display(b_dp), .data_to_reg(b_dtr),
    .pc_butt(b_pc), .halted(b_h), .state(b_st)
`ifdef CTRL_RETIRE_CNT_EN
    , .retired_count(b_rc)
`endif
  );

  // Vector layout: {state[2:0], halted, ce, rd, wr, we, alu_imm, display, dtr[1:0], pc}
  logic [12:0] obs_a, obs_b;
  assign obs_a = {a_st, a_h, a_ce, a_rd, a_wr, a_we, a_ai, a_dp, a_dtr, a_pc};
  assign obs_b = {b_st, b_h, b_ce, b_rd, b_wr, b_we, b_ai, b_dp, b_dtr, b_pc};

  int compares = 0;
  int fails    = 0;

  // Reference model state, one slot per instance.
  int          ex_c[2] = '{1, 3};
  int          mw_c[2] = '{1, 3};
  logic [12:0] qa[$];
  logic [12:0] qb[$];
  logic [12:0] exp_v[2];
  bit          halt_m[2];
  bit          pend_m[2];
  bit          idle_m[2];
  logic [15:0] rc_m[2];

  function automatic logic [12:0] mk(input int st, input bit h, input bit ce, input bit rd,
                                     input bit wr, input bit we, input bit ai, input bit dp,
                                     input logic [1:0] dtr, input bit pc);
    return {3'(st), h, ce, rd, wr, we, ai, dp, dtr, pc};
  endfunction

  task automatic qpush(input int i, input logic [12:0] v);
    if (i == 0) qa.push_back(v); else qb.push_back(v);
  endtask

  task automatic qpop(input int i, output logic [12:0] v);
    if (i == 0) v = qa.pop_front(); else v = qb.pop_front();
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? qa.size() : qb.size();
  endfunction

  // Builds the expected per-cycle outputs from DECODE through PC_UPD.
  task automatic build(input int i);
    bit ai, dp;
    logic [1:0] dtr;
    int kind;  // 0 exec, 1 load, 2 store, 3 writeback-only, 4 pc-only, 5 halt
    ai = (instr_type == 2'b01);
    dp = (instr_type == 2'b11) && (opcode == 5'b10111);
    dtr = 2'b00;
    kind = 0;
    if (instr_type == 2'b10) begin
      case (opcode)
        5'b00001: begin kind = 1; dtr = 2'b01; end
        5'b00010: kind = 2;
        5'b00011: begin kind = 3; dtr = 2'b11; end
        5'b00100: begin kind = 3; dtr = 2'b10; end
        5'b11111: kind = 5;
        default:  kind = 4;
      endcase
    end
    qpush(i, mk(2, 0, 0, 0, 0, 0, ai, dp, dtr, 0));
    case (kind)
      0: for (int k = 0; k < ex_c[i]; k++) qpush(i, mk(3, 0, 1, 0, 0, 0, ai, dp, dtr, 0));
      1: begin
        for (int k = 0; k < mw_c[i]; k++) qpush(i, mk(4, 0, 0, 1, 0, 0, ai, dp, dtr, 0));
        qpush(i, mk(5, 0, 1, 1, 0, 1, ai, dp, dtr, 0));
      end
      2: qpush(i, mk(4, 0, 1, 0, 1, 0, ai, dp, dtr, 0));
      3: qpush(i, mk(5, 0, 1, 0, 0, 1, ai, dp, dtr, 0));
      default: ;
    endcase
    if (kind == 5) halt_m[i] = 1'b1;
    else qpush(i, mk(6, 0, 0, 0, 0, 0, ai, dp, dtr, 1));
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    for (int i = 0; i < 2; i++) begin
      exp_v[i]  = '0;
      halt_m[i] = 1'b0;
      pend_m[i] = 1'b0;
      idle_m[i] = 1'b1;
      rc_m[i]   = 16'd0;
    end
  endtask

  task automatic model_edge(input int i);
    if (exp_v[i][12:10] == 3'd6) rc_m[i] = rc_m[i] + 16'd1;
    if (pend_m[i]) begin
      pend_m[i] = 1'b0;
      build(i);
      qpop(i, exp_v[i]);
    end else if (qsize(i) > 0) begin
      qpop(i, exp_v[i]);
    end else if (halt_m[i]) begin
      exp_v[i] = mk(7, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    end else if (run || (step && idle_m[i])) begin
      exp_v[i]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
      pend_m[i] = 1'b1;
      idle_m[i] = 1'b0;
    end else begin
      exp_v[i]  = '0;
      idle_m[i] = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compares++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("a_outputs", 32'(obs_a), 32'(exp_v[0]));
    chk("b_outputs", 32'(obs_b), 32'(exp_v[1]));
    chk("a_exclusive", 32'({a_wr & a_we, a_pc & (a_wr | a_we)}), 32'(0));
    chk("b_exclusive", 32'({b_wr & b_we, b_pc & (b_wr | b_we)}), 32'(0));
`ifdef CTRL_RETIRE_CNT_EN
    chk("a_retired", 32'(a_rc), 32'(rc_m[0]));
    chk("b_retired", 32'(b_rc), 32'(rc_m[1]));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else begin
      model_edge(0);
      model_edge(1);
    end
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 reset = 1'b0;
  endtask

  int n_pc_a, n_pc_b, n_rd_b, n_busy_b, n_we_b, n_wr_a, n_wr_b;
  logic [4:0] ops[8] = '{5'b00001, 5'b00010, 5'b00011, 5'b00100,
                         5'b10100, 5'b10111, 5'b00000, 5'b00101};

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; instr_type = 2'b00; opcode = 5'b00000;
    model_reset();
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Free-run ALU_REG
    run = 1'b1; instr_type = 2'b00; opcode = 5'b00000;
    n_pc_a = 0; n_pc_b = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_pc_a += int'(a_pc);
      n_pc_b += int'(b_pc);
    end
    chk("freerun_pc_a", 32'(n_pc_a), 32'(3));
    chk("freerun_pc_b", 32'(n_pc_b), 32'(2));

    // Reset mid-EXEC
    async_reset();
    n_pc_a = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_pc_a += int'(a_pc) + int'(b_pc);
    end
    chk("midexec_state_b", 32'(b_st), 32'(3));
    async_reset();
    chk("midexec_state_a", 32'(a_st), 32'(0));
    chk("midexec_no_pc", 32'(n_pc_a), 32'(0));
    run = 1'b0;
    tick();

    // LOAD single-stepped; instance b has MEM_WAIT=3
    instr_type = 2'b10; opcode = 5'b00001; step = 1'b1;
    n_rd_b = 0; n_busy_b = 0; n_we_b = 0;
    for (int k = 0; k < 11; k++) begin
      tick();
      step = 1'b0;
      n_rd_b   += int'(b_rd);
      n_busy_b += int'(b_st != 3'd0);
      n_we_b   += int'(b_we);
    end
    chk("load_rd_cycles", 32'(n_rd_b), 32'(4));
    chk("load_total_cycles", 32'(n_busy_b), 32'(7));
    chk("load_we_cycles", 32'(n_we_b), 32'(1));

    // Single-step STORE with a second step during MEM
    opcode = 5'b00010; step = 1'b1;
    n_wr_a = 0; n_wr_b = 0; n_pc_a = 0;
    for (int k = 0; k < 9; k++) begin
      tick();
      step = (k == 2);
      n_wr_a += int'(a_wr);
      n_wr_b += int'(b_wr);
      n_pc_a += int'(a_pc);
    end
    chk("step_wr_a", 32'(n_wr_a), 32'(1));
    chk("step_wr_b", 32'(n_wr_b), 32'(1));
    chk("step_pc_a", 32'(n_pc_a), 32'(1));
    chk("step_final_state", 32'({a_st, b_st}), 32'(0));

    // HALT is sticky; step toggling and run are ignored
    run = 1'b1; opcode = 5'b11111;
    for (int k = 0; k < 4; k++) tick();
    n_pc_a = 0;
    for (int k = 0; k < 10; k++) begin
      step = ~step;
      tick();
      n_pc_a += int'(a_pc) + int'(b_pc);
    end
    chk("halt_no_pc", 32'(n_pc_a), 32'(0));
    chk("halt_state", 32'({a_st, a_h, b_st, b_h}), 32'({3'd7, 1'b1, 3'd7, 1'b1}));
    step = 1'b0;
    async_reset();
    chk("halt_reset_state", 32'({a_st, b_st}), 32'(0));

`ifdef CTRL_RETIRE_CNT_EN
    // Three NOPs then HALT
    run = 1'b1; opcode = 5'b00000;
    for (int k = 0; k < 9; k++) tick();
    opcode = 5'b11111;
    for (int k = 0; k < 8; k++) tick();
    chk("retire_a_3", 32'(a_rc), 32'(3));
    chk("retire_b_3", 32'(b_rc), 32'(3));
    async_reset();
    chk("retire_cleared", 32'({a_rc, b_rc}), 32'(0));
`endif

    // Randomized traffic
    run = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(19) == 0) run = ~run;
      step = ($urandom_range(3) == 0);
      instr_type = 2'($urandom_range(3));
      opcode = ($urandom_range(1) == 0) ? ops[$urandom_range(7)] : 5'($urandom_range(31));
      if (opcode == 5'b11111 && $urandom_range(7) != 0) opcode = 5'b00000;
      if (((halt_m[0] || halt_m[1]) && $urandom_range(3) == 0) || $urandom_range(99) == 0)
        async_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
